// File: rtl/vga_tile_renderer.sv
// vga_tile_renderer
// Pixel-colour generator sitting between the VGA timing generator and the
// DAC pins. Renders per-tile entity sprites out of a writable sprite RAM, or
// one of three built-in test patterns (colour bars, tile checkerboard, solid
// white). The rendering mode and the blink phase change only at frame start.
// Output is a two-stage registered pipeline with DE and the frame-start flag
// delayed to stay aligned with the colour.

module vga_tile_renderer #(
  parameter int COLOR_BITS   = 1,
  parameter int ENT_W        = 2,
  parameter int NUM_ENT      = 4,
  parameter int TILE_W       = 16,
  parameter int TILE_H       = 16,
  parameter int V_ACTIVE     = 480,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                                      iVGA_CLK,
  input  logic                                      reset,
  input  logic [9:0]                                iVGA_X,
  input  logic [9:0]                                iVGA_Y,
  input  logic                                      iVGA_DE,
  input  logic [1:0]                                iMode,
  input  logic [ENT_W-1:0]                          iEnt,
  input  logic                                      iBlink,
  input  logic                                      iSpr_we,
  input  logic [$clog2(NUM_ENT*TILE_W*TILE_H)-1:0]  iSpr_addr,
  input  logic [3*COLOR_BITS-1:0]                   iSpr_data,
  output logic [COLOR_BITS-1:0]                     oRed,
  output logic [COLOR_BITS-1:0]                     oGreen,
  output logic [COLOR_BITS-1:0]                     oBlue,
  output logic                                      oDE,
  output logic                                      oFrame_start
);

  // Derived sizes
  localparam int SPR_DEPTH = NUM_ENT * TILE_W * TILE_H;
  localparam int ADDR_W    = $clog2(SPR_DEPTH);
  localparam int XOFF_W    = $clog2(TILE_W);
  localparam int YOFF_W    = $clog2(TILE_H);
  localparam int RAW_W     = ENT_W + YOFF_W + XOFF_W;
  localparam int CNT_W     = $clog2(2 * BLINK_FRAMES);
  localparam int BAR_PITCH = V_ACTIVE / 8;
  localparam int WORD_W    = 3 * COLOR_BITS;

  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(2 * BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_PH_OFF = CNT_W'(BLINK_FRAMES);

  typedef enum logic [1:0] {
    MODE_SPRITE  = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_WHITE   = 2'd3
  } mode_t;

  // Widen a 3-bit on/off colour to full channels ({R,G,B}, all-ones when on).
  function automatic logic [WORD_W-1:0] expand_rgb(input logic [2:0] rgb);
    return {{COLOR_BITS{rgb[2]}}, {COLOR_BITS{rgb[1]}}, {COLOR_BITS{rgb[0]}}};
  endfunction

  // Colour-bar palette: white, magenta, yellow, red, cyan, blue, green, black.
  function automatic logic [2:0] bar_code(input logic [2:0] idx);
    logic [2:0] code;
    case (idx)
      3'd0:    code = 3'b111;
      3'd1:    code = 3'b101;
      3'd2:    code = 3'b110;
      3'd3:    code = 3'b100;
      3'd4:    code = 3'b011;
      3'd5:    code = 3'b001;
      3'd6:    code = 3'b010;
      default: code = 3'b000;
    endcase
    return code;
  endfunction

  // Frame-level state
  mode_t              mode_r;
  logic [CNT_W-1:0]   cnt_r;

  // Stage-0 combinational decode of the incoming pixel
  logic               frame_start;
  mode_t              mode_eff;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   cnt_eff;
  logic               blink_off;
  logic [9:0]         bar_full;
  logic [2:0]         bar_idx;
  logic               bar_valid;
  logic               parity;
  logic [RAW_W-1:0]   rd_raw;
  logic [ADDR_W-1:0]  rd_addr;

  // Sprite RAM
  logic [WORD_W-1:0]  spr_mem [SPR_DEPTH];
  logic [WORD_W-1:0]  ram_q_r;

  // Stage-1 registers
  mode_t              mode_s1_r;
  logic [ENT_W-1:0]   ent_s1_r;
  logic               blink_s1_r;
  logic               blink_off_s1_r;
  logic               de_s1_r;
  logic               fs_s1_r;
  logic               parity_s1_r;
  logic [2:0]         bar_idx_s1_r;
  logic               bar_valid_s1_r;

  // Stage-2 combinational colour
  logic               ent_ok;
  logic [WORD_W-1:0]  pix_rgb;

  // Decode the incoming pixel: frame start, effective mode/phase, tile fields, RAM address.
  always_comb begin
    frame_start = 1'b0;
    mode_eff    = mode_r;
    cnt_inc     = cnt_r;
    cnt_eff     = cnt_r;
    blink_off   = 1'b0;
    bar_full    = 10'd0;
    bar_idx     = 3'd0;
    bar_valid   = 1'b0;
    parity      = 1'b0;
    rd_raw      = '0;
    rd_addr     = '0;

    frame_start = (iVGA_X == 10'd0) && (iVGA_Y == 10'd0);

    if (cnt_r == CNT_MAX) begin
      cnt_inc = '0;
    end else begin
      cnt_inc = cnt_r + CNT_W'(1);
    end

    // Pixel (0,0) already belongs to the new frame, so it sees the new mode and phase.
    if (frame_start) begin
      mode_eff = mode_t'(iMode);
      cnt_eff  = cnt_inc;
    end else begin
      mode_eff = mode_r;
      cnt_eff  = cnt_r;
    end

    blink_off = (cnt_eff >= CNT_PH_OFF);

    bar_full = iVGA_Y / 10'(BAR_PITCH);
    if (bar_full < 10'd8) begin
      bar_valid = 1'b1;
      bar_idx   = bar_full[2:0];
    end else begin
      bar_valid = 1'b0;
      bar_idx   = 3'd0;
    end

    parity = iVGA_X[XOFF_W] ^ iVGA_Y[YOFF_W];

    // Power-of-two tiles: ent*TILE_W*TILE_H + yoff*TILE_W + xoff is a concatenation.
    rd_raw  = {iEnt, iVGA_Y[YOFF_W-1:0], iVGA_X[XOFF_W-1:0]};
    rd_addr = rd_raw[ADDR_W-1:0];
  end

  // Mode register and blink frame counter advance only at frame start.
  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      mode_r <= MODE_SPRITE;
      cnt_r  <= '0;
    end else begin
      mode_r <= mode_eff;
      cnt_r  <= cnt_eff;
    end
  end

  // Sprite RAM write port; contents survive reset.
  always_ff @(posedge iVGA_CLK) begin
    if (iSpr_we) begin
      spr_mem[iSpr_addr] <= iSpr_data;
    end
  end

  // Sprite RAM read port, one-cycle latency; a same-address write returns the old word.
  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      ram_q_r <= '0;
    end else begin
      ram_q_r <= spr_mem[rd_addr];
    end
  end

  // Stage 1: capture decoded pixel attributes alongside the RAM read.
  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      mode_s1_r      <= MODE_SPRITE;
      ent_s1_r       <= '0;
      blink_s1_r     <= 1'b0;
      blink_off_s1_r <= 1'b0;
      de_s1_r        <= 1'b0;
      fs_s1_r        <= 1'b0;
      parity_s1_r    <= 1'b0;
      bar_idx_s1_r   <= 3'd0;
      bar_valid_s1_r <= 1'b0;
    end else begin
      mode_s1_r      <= mode_eff;
      ent_s1_r       <= iEnt;
      blink_s1_r     <= iBlink;
      blink_off_s1_r <= blink_off;
      de_s1_r        <= iVGA_DE;
      fs_s1_r        <= frame_start;
      parity_s1_r    <= parity;
      bar_idx_s1_r   <= bar_idx;
      bar_valid_s1_r <= bar_valid;
    end
  end

  // Select the pixel colour for the current mode; blanking forces black.
  always_comb begin
    ent_ok  = 1'b0;
    pix_rgb = '0;

    ent_ok = (ent_s1_r != '0) && (32'(ent_s1_r) < 32'(NUM_ENT));

    if (!de_s1_r) begin
      pix_rgb = '0;
    end else begin
      case (mode_s1_r)
        MODE_SPRITE: begin
          if (ent_ok && !(blink_s1_r && blink_off_s1_r)) begin
            pix_rgb = ram_q_r;
          end else begin
            pix_rgb = '0;
          end
        end
        MODE_BARS: begin
          if (bar_valid_s1_r) begin
            pix_rgb = expand_rgb(bar_code(bar_idx_s1_r));
          end else begin
            pix_rgb = '0;
          end
        end
        MODE_CHECKER: pix_rgb = expand_rgb({3{parity_s1_r}});
        MODE_WHITE:   pix_rgb = expand_rgb(3'b111);
        default:      pix_rgb = '0;
      endcase
    end
  end

  // Stage 2: registered outputs to the DAC, DE and frame-start kept aligned.
  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      oRed         <= '0;
      oGreen       <= '0;
      oBlue        <= '0;
      oDE          <= 1'b0;
      oFrame_start <= 1'b0;
    end else begin
      oRed         <= pix_rgb[3*COLOR_BITS-1:2*COLOR_BITS];
      oGreen       <= pix_rgb[2*COLOR_BITS-1:COLOR_BITS];
      oBlue        <= pix_rgb[COLOR_BITS-1:0];
      oDE          <= de_s1_r;
      oFrame_start <= fs_s1_r;
    end
  end

endmodule
